// File: rtl/demo_pkg.sv
// Shared constants and types for the PCPI RV32M multiply unit.
// Imported by the decode/handshake top and the multiply datapath.
package demo_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'd1;

  typedef enum logic [1:0] {
    F3_MUL    = 2'd0,
    F3_MULH   = 2'd1,
    F3_MULHSU = 2'd2,
    F3_MULHU  = 2'd3
  } funct3_e;

  function automatic logic rs1_signed(funct3_e op);
    return (op == F3_MULH) || (op == F3_MULHSU);
  endfunction

  function automatic logic rs2_signed(funct3_e op);
    return op == F3_MULH;
  endfunction

endpackage

// File: rtl/demo_mul_core.sv
// Iterative shift-and-add 64-bit multiplier datapath.
// Loads on start, runs 64/STEPS_AT_ONCE cycles, then pulses ready.
module demo_mul_core
  import demo_pkg::*;
#(
  parameter int STEPS_AT_ONCE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  funct3_e     op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int K  = 64 / STEPS_AT_ONCE;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  logic [63:0]   a_q, b_q, acc_q;
  logic [63:0]   a_n, b_n, acc_n;
  logic [CW-1:0] cnt_q;
  logic          run_q, fin_q, lo_q;

  always_comb begin
    a_n   = a_q;
    b_n   = b_q;
    acc_n = acc_q;
    for (int j = 0; j < STEPS_AT_ONCE; j++) begin
      if (b_n[0]) acc_n = acc_n + a_n;
      a_n = a_n << 1;
      b_n = b_n >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      fin_q <= 1'b0;
      lo_q  <= 1'b0;
      ready <= 1'b0;
      rd    <= '0;
    end else begin
      ready <= 1'b0;
      if (fin_q) begin
        ready <= 1'b1;
        rd    <= lo_q ? acc_q[31:0] : acc_q[63:32];
        fin_q <= 1'b0;
      end
      if (start) begin
        a_q   <= {{32{rs1_signed(op) & rs1[31]}}, rs1};
        b_q   <= {{32{rs2_signed(op) & rs2[31]}}, rs2};
        acc_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
        fin_q <= 1'b0;
        lo_q  <= op == F3_MUL;
      end else if (run_q) begin
        a_q   <= a_n;
        b_q   <= b_n;
        acc_q <= acc_n;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          run_q <= 1'b0;
          fin_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demo.sv
// PCPI RV32M multiply coprocessor: decode and handshake.
// Starts the datapath on the rising edge of pcpi_wait.
module demo
  import demo_pkg::*;
#(
  parameter int STEPS_AT_ONCE = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  logic    match, wait_q, start, ready;
  funct3_e op;
  logic    unused_insn;

  assign match = pcpi_valid
              && pcpi_insn[6:0] == OPCODE_OP
              && pcpi_insn[31:25] == FUNCT7_MULDIV
              && !pcpi_insn[14];

  assign op          = funct3_e'(pcpi_insn[13:12]);
  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcpi_wait <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      pcpi_wait <= match;
      wait_q    <= pcpi_wait;
    end
  end

  // Only a fresh acceptance starts work, so valid lingering past ready is harmless
  assign start = pcpi_wait & ~wait_q;

  demo_mul_core #(
    .STEPS_AT_ONCE(STEPS_AT_ONCE)
  ) u_core (
    .clk  (clk),
    .rst_n(resetn),
    .start(start),
    .op   (op),
    .rs1  (pcpi_rs1),
    .rs2  (pcpi_rs2),
    .ready(ready),
    .rd   (pcpi_rd)
  );

  assign pcpi_ready = ready;
  assign pcpi_wr    = ready;

endmodule

// File: tb/tb_demo.sv
// Directed and random checks for the PCPI multiply unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_demo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0;
  logic [31:0] pcpi_rs1 = '0;
  logic [31:0] pcpi_rs2 = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;

  int checks = 0;
  int errors = 0;
  logic [31:0] xs = 32'h1234_5678;

  localparam int LAT = 67;

  demo #(.STEPS_AT_ONCE(1)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_insn(input logic [6:0] f7,
                                          input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      2'd0: p = ua * ub;
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f3 == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Drives one op from a falling edge, waits for ready, then drops valid
  task automatic do_op(input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] rd,
                       output int lat, output bit wait_ok,
                       output logic wr);
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    pcpi_valid = 1'b1;
    lat = 0;
    wait_ok = 1'b1;
    rd = 'x;
    wr = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (pcpi_ready) begin
        lat = c;
        rd = pcpi_rd;
        wr = pcpi_wr;
        break;
      end
      if (!pcpi_wait) wait_ok = 1'b0;
    end
    pcpi_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pcpi_wr, pcpi_wait, pcpi_ready} !== 3'b000 || pcpi_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset: wr=%b wait=%b ready=%b rd=%h, want 0/0/0/0",
               pcpi_wr, pcpi_wait, pcpi_ready, pcpi_rd);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] rd;
    int lat;
    bit wok;
    logic wr;
    do_op(mk_insn(7'd1, 3'd0), 32'd3, 32'd5, rd, lat, wok, wr);
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL mul_timeout: no ready within 200 cycles");
    end
    checks++;
    if (rd !== 32'd15) begin
      errors++;
      $display("FAIL mul_rd: got %h want %h", rd, 32'd15);
    end
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL mul_latency: got %0d want %0d", lat, LAT);
    end
    checks++;
    if (!wok || wr !== 1'b1) begin
      errors++;
      $display("FAIL mul_wait_wr: wait_ok=%b wr=%b want 1/1", wok, wr);
    end
    @(negedge clk);
    checks++;
    if (pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_rd !== 32'd15) begin
      errors++;
      $display("FAIL mul_pulse: ready=%b wr=%b rd=%h want 0/0/0000000f",
               pcpi_ready, pcpi_wr, pcpi_rd);
    end
  endtask

  task automatic test_signed();
    logic [1:0]  f3 [4] = '{2'd1, 2'd3, 2'd2, 2'd1};
    logic [31:0] va [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'h80000000};
    logic [31:0] ve [4] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    logic [31:0] rd;
    int lat;
    bit wok;
    logic wr;
    for (int i = 0; i < 4; i++) begin
      do_op(mk_insn(7'd1, {1'b0, f3[i]}), va[i], vb[i], rd, lat, wok, wr);
      checks++;
      if (rd !== ve[i] || lat != LAT) begin
        errors++;
        $display("FAIL signed_%0d: rd=%h lat=%0d want rd=%h lat=%0d",
                 i, rd, lat, ve[i], LAT);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_nonmatch();
    bit bad;
    bad = 1'b0;
    pcpi_insn  = mk_insn(7'd0, 3'd0);
    pcpi_rs1   = 32'd7;
    pcpi_rs2   = 32'd9;
    pcpi_valid = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL nonmatch_add: handshake asserted=1 want 0");
    end
    bad = 1'b0;
    pcpi_insn = mk_insn(7'd1, 3'd4);
    repeat (30) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL nonmatch_div: handshake asserted=1 want 0");
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int extra;
    lat = 0;
    extra = 0;
    pcpi_insn  = mk_insn(7'd1, 3'd0);
    pcpi_rs1   = 32'd6;
    pcpi_rs2   = 32'd7;
    pcpi_valid = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (pcpi_ready) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != LAT || pcpi_rd !== 32'd42) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d rd=%h want %0d/0000002a",
               lat, pcpi_rd, LAT);
    end
    @(negedge clk);
    pcpi_valid = 1'b0;
    repeat (80) begin
      if (pcpi_ready) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_restart: extra ready pulses=%0d want 0", extra);
    end
  endtask

  task automatic test_abort();
    int lat;
    lat = 0;
    pcpi_insn  = mk_insn(7'd1, 3'd3);
    pcpi_rs1   = 32'h0001_0000;
    pcpi_rs2   = 32'h0003_0000;
    pcpi_valid = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 10) pcpi_valid = 1'b0;
      if (pcpi_ready) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat != LAT || pcpi_rd !== 32'd3) begin
      errors++;
      $display("FAIL abort: lat=%0d rd=%h want %0d/00000003",
               lat, pcpi_rd, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int seen;
    seen = 0;
    pcpi_insn  = mk_insn(7'd1, 3'd0);
    pcpi_rs1   = 32'd11;
    pcpi_rs2   = 32'd13;
    pcpi_valid = 1'b1;
    repeat (20) @(negedge clk);
    pcpi_valid = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if ({pcpi_wr, pcpi_wait, pcpi_ready} !== 3'b000 || pcpi_rd !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: wr=%b wait=%b ready=%b rd=%h want 0",
               pcpi_wr, pcpi_wait, pcpi_ready, pcpi_rd);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wr) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_midop: ready pulses=%0d want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [1:0]  f3;
    logic [31:0] a, b, exp, rd;
    int lat;
    bit wok;
    logic wr;
    for (int i = 0; i < 100; i++) begin
      xs = xorshift(xs);
      f3 = xs[1:0];
      xs = xorshift(xs);
      a = xs;
      xs = xorshift(xs);
      b = xs;
      exp = ref_mul(f3, a, b);
      do_op(mk_insn(7'd1, {1'b0, f3}), a, b, rd, lat, wok, wr);
      checks++;
      if (rd !== exp || lat != LAT) begin
        errors++;
        $display("FAIL rand_%0d: f3=%0d a=%h b=%h rd=%h lat=%0d want %h/%0d",
                 i, f3, a, b, rd, lat, exp, LAT);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_signed();
    test_nonmatch();
    test_back_to_back();
    test_abort();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
